// File: rtl/reg_bank_scheduler_if.sv
// Write-port bundle between the three register-file writers (ALU, load unit, CSR)
// and the bank scheduler, plus the scheduler's registered write/clear outputs.
interface reg_bank_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [2:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              clr_all;
  logic [2:0]        gnt;
  logic              wr_en;
  logic              wr_clear;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              sweep_done;

  modport master (
    output req, addr0, addr1, addr2, data0, data1, data2, clr_all,
    input  gnt, wr_en, wr_clear, wr_addr, wr_data, busy, sweep_done
  );

  modport slave (
    input  req, addr0, addr1, addr2, data0, data1, data2, clr_all,
    output gnt, wr_en, wr_clear, wr_addr, wr_data, busy, sweep_done
  );
endinterface

// File: rtl/reg_bank_scheduler.sv
// Round-robin write-port scheduler for a register bank with a clear-all sweep.
// Every output is a flop; the sweep walks registers 1..2^ADDR_W-1, one per cycle.
module reg_bank_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 clearN,
  reg_bank_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [2:0]        gnt_q, gnt_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_clear_q, wr_clear_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;

  logic [ADDR_W-1:0] addr_arr [3];
  logic [DATA_W-1:0] data_arr [3];
  logic [2:0]        elig;
  logic [1:0]        sel;
  logic [1:0]        cand;
  logic              found;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign addr_arr[0] = bus.addr0;
  assign addr_arr[1] = bus.addr1;
  assign addr_arr[2] = bus.addr2;
  assign data_arr[0] = bus.data0;
  assign data_arr[1] = bus.data1;
  assign data_arr[2] = bus.data2;

  // A requester still showing its grant this cycle is the same request, not a new one.
  assign elig = bus.req & ~gnt_q;

  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < 3; k++) begin
      cand = nxt(cand);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    gnt_d        = 3'b000;
    wr_en_d      = 1'b0;
    wr_clear_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = 1'b0;
    sweep_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_all) begin
          state_d = SWEEP;
          cnt_d   = ADDR_W'(1);
        end else if (found) begin
          gnt_d     = 3'b001 << sel;
          wr_addr_d = addr_arr[sel];
          wr_data_d = data_arr[sel];
          wr_en_d   = |addr_arr[sel];
          ptr_d     = sel;
        end
      end
      SWEEP: begin
        wr_clear_d = 1'b1;
        busy_d     = 1'b1;
        wr_addr_d  = cnt_q;
        wr_data_d  = '0;
        cnt_d      = cnt_q + 1'b1;
        if (&cnt_q) state_d = DONE;
      end
      DONE: begin
        sweep_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clearN) begin
    if (!clearN) begin
      state_q      <= IDLE;
      cnt_q        <= ADDR_W'(1);
      ptr_q        <= 2'd2;
      gnt_q        <= 3'b000;
      wr_en_q      <= 1'b0;
      wr_clear_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      wr_en_q      <= wr_en_d;
      wr_clear_q   <= wr_clear_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_clear   = wr_clear_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = sweep_done_q;

endmodule

// File: tb/tb_reg_bank_scheduler.sv
// Bench for reg_bank_scheduler: vector table, hand-written sweep/reset/hold
// sequences, then random traffic against a queue-based reference model.
module tb_reg_bank_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 1 << AW;

  logic clk = 1'b0;
  logic clearN;
  always #5 clk = ~clk;

  reg_bank_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_bank_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .clearN (clearN),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  req;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  eg;
    logic        een;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [7];

  // model state for the random phase
  logic [43:0] mq [$];
  logic [2:0]  m_gnt;
  int          m_last;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        pend  [3];
  logic [4:0]  paddr [3];
  logic [31:0] pdata [3];

  function automatic logic [43:0] mk(input logic [2:0] g, input logic e, input logic c,
                                     input logic b, input logic d, input logic [4:0] a,
                                     input logic [31:0] dt);
    return {g, e, c, b, d, a, dt};
  endfunction

  function automatic logic [43:0] outs();
    return {bus.gnt, bus.wr_en, bus.wr_clear, bus.busy, bus.sweep_done, bus.wr_addr, bus.wr_data};
  endfunction

  task automatic check(input string nm, input logic [43:0] exp);
    logic [43:0] act;
    act = outs();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got gnt=%b en=%b clr=%b busy=%b done=%b addr=%0d data=%h, want gnt=%b en=%b clr=%b busy=%b done=%b addr=%0d data=%h",
               nm, act[43:41], act[40], act[39], act[38], act[37], act[36:32], act[31:0],
               exp[43:41], exp[40], exp[39], exp[38], exp[37], exp[36:32], exp[31:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req = 3'b000; bus.clr_all = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.data0 = '0; bus.data1 = '0; bus.data2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    clearN = 1'b0;
    #2;
    check("async_reset", mk(3'b000, 0, 0, 0, 0, 5'd0, 32'h0));
    @(negedge clk);
    clearN = 1'b1;
  endtask

  task automatic set_req(input logic [2:0] r, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
    bus.req = r;
    bus.addr0 = a0; bus.addr1 = a1; bus.addr2 = a2;
    bus.data0 = d0; bus.data1 = d1; bus.data2 = d2;
  endtask

  initial begin
    logic [43:0] exp;
    logic [2:0]  el;
    logic        hit;
    int          c;
    int          seen;
    // req, a0,a1,a2, d0,d1,d2, exp gnt, exp wr_en, exp addr, exp data
    tbl[0] = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h00001234, 32'h0, 3'b010, 1'b0, 5'd0, 32'h00001234};
    tbl[2] = '{3'b111, 5'd3, 5'd7, 5'd9, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 3'b100, 1'b1, 5'd9, 32'hC2C2C2C2};
    tbl[3] = '{3'b011, 5'd4, 5'd6, 5'd0, 32'h11111111, 32'h22222222, 32'h0, 3'b001, 1'b1, 5'd4, 32'h11111111};
    tbl[4] = '{3'b101, 5'd8, 5'd0, 5'd31, 32'h33333333, 32'h0, 32'h44444444, 3'b100, 1'b1, 5'd31, 32'h44444444};
    tbl[5] = '{3'b110, 5'd0, 5'd12, 5'd13, 32'h0, 32'h55555555, 32'h66666666, 3'b010, 1'b1, 5'd12, 32'h55555555};
    tbl[6] = '{3'b000, 5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 32'h9, 3'b000, 1'b0, 5'd12, 32'h55555555};

    idle_inputs();
    clearN = 1'b1;
    #2 clearN = 1'b0;
    #1 check("reset_state", mk(3'b000, 0, 0, 0, 0, 5'd0, 32'h0));
    @(negedge clk);
    @(negedge clk);
    clearN = 1'b1;

    // table: each vector applied one cycle, then one idle cycle
    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      step();
      check($sformatf("vec%0d", i), mk(tbl[i].eg, tbl[i].een, 0, 0, 0, tbl[i].ea, tbl[i].ed));
      $display("vec %0d req=%b -> gnt=%b wr_en=%b addr=%0d data=%h", i, tbl[i].req, bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data);
      idle_inputs();
      step();
      check($sformatf("vec%0d_idle", i), mk(3'b000, 0, 0, 0, 0, tbl[i].ea, tbl[i].ed));
    end

    // fairness: each requester drops after its grant and re-raises next cycle
    do_reset();
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'hF0, 32'hF1, 32'hF2);
    step(); check("fair_0", mk(3'b001, 1, 0, 0, 0, 5'd1, 32'hF0));
    bus.req = 3'b110;
    step(); check("fair_1", mk(3'b010, 1, 0, 0, 0, 5'd2, 32'hF1));
    bus.req = 3'b101;
    step(); check("fair_2", mk(3'b100, 1, 0, 0, 0, 5'd3, 32'hF2));
    bus.req = 3'b011;
    step(); check("fair_3", mk(3'b001, 1, 0, 0, 0, 5'd1, 32'hF0));
    $display("fairness sequence gnt order 001 010 100 001 checked");
    idle_inputs();
    step(); check("fair_idle", mk(3'b000, 0, 0, 0, 0, 5'd1, 32'hF0));

    // held request: ineligible on the cycle its grant is visible
    set_req(3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0);
    step(); check("hold_gnt1", mk(3'b001, 1, 0, 0, 0, 5'd9, 32'h99));
    step(); check("hold_inelig", mk(3'b000, 0, 0, 0, 0, 5'd9, 32'h99));
    step(); check("hold_gnt2", mk(3'b001, 1, 0, 0, 0, 5'd9, 32'h99));
    idle_inputs();
    step(); check("hold_idle", mk(3'b000, 0, 0, 0, 0, 5'd9, 32'h99));
    $display("held request sequence done");

    // full sweep with a competing ALU request
    set_req(3'b001, 5'd7, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0);
    bus.clr_all = 1'b1;
    step(); check("sweep_enter", mk(3'b000, 0, 0, 0, 0, 5'd9, 32'h99));
    bus.clr_all = 1'b0;
    for (int a = 1; a < NREG; a++) begin
      if (a == 5) bus.clr_all = 1'b1;
      step(); check($sformatf("sweep_a%0d", a), mk(3'b000, 0, 1, 1, 0, 5'(a), 32'h0));
    end
    bus.clr_all = 1'b0;
    step(); check("sweep_done", mk(3'b000, 0, 0, 0, 1, 5'd31, 32'h0));
    step(); check("sweep_post_gnt", mk(3'b001, 1, 0, 0, 0, 5'd7, 32'h77));
    $display("sweep of %0d registers done, ALU granted after", NREG - 1);
    idle_inputs();
    step(); check("sweep_post_idle", mk(3'b000, 0, 0, 0, 0, 5'd7, 32'h77));

    // reset in the middle of a sweep
    bus.clr_all = 1'b1;
    step();
    bus.clr_all = 1'b0;
    seen = 0;
    for (int n = 0; n < 40 && seen == 0; n++) begin
      step();
      if (bus.wr_clear && bus.wr_addr == 5'd10) seen = 1;
    end
    total++;
    if (seen == 0) begin
      bad++;
      $display("FAIL midsweep_reach: got no cycle with wr_addr=10 during sweep, want one within 40 cycles");
    end
    clearN = 1'b0;
    #2 check("midsweep_async", mk(3'b000, 0, 0, 0, 0, 5'd0, 32'h0));
    step(); check("midsweep_held", mk(3'b000, 0, 0, 0, 0, 5'd0, 32'h0));
    @(negedge clk);
    clearN = 1'b1;
    set_req(3'b100, 5'd0, 5'd0, 5'd21, 32'h0, 32'h0, 32'h2121);
    step(); check("midsweep_release_gnt", mk(3'b100, 1, 0, 0, 0, 5'd21, 32'h2121));
    idle_inputs();
    step(); check("midsweep_no_done", mk(3'b000, 0, 0, 0, 0, 5'd21, 32'h2121));
    $display("reset mid-sweep sequence done");

    // random traffic against the reference model
    do_reset();
    m_gnt = 3'b000; m_last = 2; m_addr = '0; m_data = '0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (m_gnt[i]) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pdata[i] = $urandom;
        end
      end
      set_req({pend[2], pend[1], pend[0]}, paddr[0], paddr[1], paddr[2], pdata[0], pdata[1], pdata[2]);
      bus.clr_all = ($urandom_range(0, 59) == 0);

      if (mq.size() > 0) begin
        exp = mq.pop_front();
      end else if (bus.clr_all) begin
        exp = mk(3'b000, 0, 0, 0, 0, m_addr, m_data);
        for (int a = 1; a < NREG; a++) mq.push_back(mk(3'b000, 0, 1, 1, 0, 5'(a), 32'h0));
        mq.push_back(mk(3'b000, 0, 0, 0, 1, 5'(NREG - 1), 32'h0));
        m_addr = 5'(NREG - 1);
        m_data = '0;
      end else begin
        el  = bus.req & ~m_gnt;
        hit = 1'b0;
        exp = mk(3'b000, 0, 0, 0, 0, m_addr, m_data);
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (!hit && el[c]) begin
            hit    = 1'b1;
            m_last = c;
            m_addr = paddr[c];
            m_data = pdata[c];
            exp    = mk(3'(1 << c), (paddr[c] != 0), 0, 0, 0, paddr[c], pdata[c]);
          end
        end
      end
      m_gnt = exp[43:41];
      step();
      check($sformatf("rand%0d", cyc), exp);
      if (bus.gnt != 3'b000 || bus.sweep_done)
        $display("rand %0d gnt=%b wr_en=%b addr=%0d data=%h sweep_done=%b", cyc, bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data, bus.sweep_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_scheduler.md
REG_BANK_SCHEDULER -- requirements
Module: reg_bank_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width (2^ADDR_W registers, register 0 hardwired zero).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clearN  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req  input  3  write requests; bit0=ALU, bit1=load unit, bit2=CSR.
REQ-006 The block SHALL have ports addr0/addr1/addr2  input  ADDR_W each  destination register per requester.
REQ-007 The block SHALL have ports data0/data1/data2  input  DATA_W each  write data per requester.
REQ-008 The block SHALL have port clr_all  input  1  request to clear registers 1..2^ADDR_W-1.
REQ-009 The block SHALL have port gnt  output  3  one-hot grant, one-cycle pulse.
REQ-010 The block SHALL have port wr_en  output  1  register bank write enable (drives flop enable).
REQ-011 The block SHALL have port wr_clear  output  1  register bank clear for the addressed register.
REQ-012 The block SHALL have ports wr_addr  output  ADDR_W and wr_data  output  DATA_W, the registered write address and data.
REQ-013 The block SHALL have port busy  output  1, high while a clear sweep is in progress.
REQ-014 The block SHALL have port sweep_done  output  1, a one-cycle pulse when a sweep completes.

Function
REQ-015 The block SHALL implement states IDLE, SWEEP and DONE, with every output registered.
REQ-016 In IDLE with clr_all=1, the block SHALL go to SWEEP and load sweep counter=1; clr_all SHALL win over any simultaneous req.
REQ-017 In IDLE with clr_all=0 and an eligible req, the block SHALL select one requester by round-robin; gnt, wr_addr and wr_data SHALL appear one cycle after sampling (latency 1).
REQ-018 Round-robin SHALL search from last-granted+1, wrapping 2->0; the last-granted pointer resets to 2, so requester 0 has first priority.
REQ-019 A requester whose gnt bit is currently 1 SHALL be ineligible in that cycle, so a req held one extra cycle is never double-granted.
REQ-020 A requester SHALL hold req, addr and data stable until it sees gnt, then drop req; the block SHALL accept a new request from it from the following cycle.
REQ-021 With a grant, wr_en SHALL be 1 only if the granted addr != 0; for addr 0 the grant SHALL still pulse with wr_en=0.
REQ-022 Back-to-back grants SHALL be possible every cycle while eligible requests exist.
REQ-023 In SWEEP, each cycle the block SHALL drive wr_clear=1, wr_en=0, wr_addr=counter and wr_data=0, then increment the counter.
REQ-024 On the cycle wr_addr=2^ADDR_W-1, the block SHALL transition to DONE; a sweep SHALL take exactly 2^ADDR_W-1 cycles (31 at default).
REQ-025 busy SHALL be 1 for every SWEEP cycle and 0 otherwise.
REQ-026 In SWEEP and DONE, gnt SHALL be 0, clr_all SHALL be ignored, and pending reqs SHALL wait.
REQ-027 DONE SHALL last one cycle with sweep_done=1, then return to IDLE; arbitration SHALL resume on the next cycle.
REQ-028 With no req and no clr_all in IDLE, gnt, wr_en and wr_clear SHALL be 0; wr_addr and wr_data SHALL hold their last values.

Reset
REQ-029 clearN=0 SHALL immediately, without a clock edge, force the following: state=IDLE, gnt=0, wr_en=0, wr_clear=0, wr_addr=0, wr_data=0, busy=0, sweep_done=0, sweep counter=1, pointer=2.
REQ-030 Reset during a sweep SHALL abort it with no sweep_done pulse; the first edge after release SHALL evaluate from IDLE.

Verification
REQ-031 Single request: after reset, req=001, addr0=5, data0=0xDEADBEEF -> next cycle gnt=001, wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
REQ-032 Fairness: req=111 held; each requester drops req after its gnt and re-raises it the next cycle -> grants 001, 010, 100, 001 on consecutive cycles.
REQ-033 x0 write: req=010, addr1=0 -> gnt=010, wr_en=0.
REQ-034 Sweep: clr_all=1 together with req=001 -> busy=1 for 31 cycles, wr_clear=1, wr_addr 1..31, gnt=0; then sweep_done pulse; ALU gnt on the following cycle.
REQ-035 Reset mid-sweep: clearN=0 at wr_addr=10 -> all outputs 0 immediately, no sweep_done; after release, req=100 -> gnt=100 one cycle later.
REQ-036 Held req: req=001 kept high for 2 cycles after gnt -> exactly one grant for the held request, then a second gnt only on the cycle after the ineligible cycle.
